neopixel_chain_tx: RTL and testbench

Parametrised serial driver for WS2812B/SK6805-class addressable LED chains. It reads pixel words from an external synchronous RAM, one pixel per read, and emits the one-wire pulse-width bit stream on dout. Once per frame it then holds the latch/reset gap. Compared with the earlier single-purpose driver, it adds:
- generic pixel width (RGB 24 / RGBW 32),
- a runtime pixel count,
- bit-order selection,
- clock-based timing with wide counters,
- an explicit start/busy/done handshake.

---
 rtl/neopixel_chain_tx.sv | 170 +++++++++++++++++
 tb/tb_neopixel_chain_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_chain_tx.sv
// neopixel_chain_tx: WS2812B/SK6805-class chain driver. Streams pixel words read from a
// synchronous RAM as pulse-width coded bits, then holds the latch gap once per frame.
module neopixel_chain_tx #(
    parameter int unsigned PIX_BITS  = 24,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TW        = 6,
    parameter int unsigned T_PERIOD  = 15,
    parameter int unsigned T1_HI     = 10,
    parameter int unsigned T0_HI     = 5,
    parameter int unsigned RW        = 16,
    parameter int unsigned T_RESET   = 600,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     num_pixels,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [PIX_BITS-1:0] ram_rd_data,
    output logic                dout,
    output logic                busy,
    output logic                done
);
    localparam int unsigned BW = $clog2(PIX_BITS);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

    state_e              state_q, state_d;
    logic [PIX_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic [TW-1:0]       clk_cnt_q, clk_cnt_d;
    logic [ADDR_W-1:0]   pix_idx_q, pix_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     npix_q, npix_d;
    logic [RW-1:0]       gap_q, gap_d;
    logic                dout_q, dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [ADDR_W:0]     num_clamped;
    logic [PIX_BITS-1:0] shifted;
    logic [TW-1:0]       hi_end;
    logic                cur_bit, last_bit, last_pix, period_end, gap_end;

    // Any request with the top bit set is at least 2**ADDR_W, so it clamps to exactly that.
    assign num_clamped = num_pixels[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : num_pixels;

    assign cur_bit    = MSB_FIRST ? shift_q[PIX_BITS-1] : shift_q[0];
    assign shifted    = MSB_FIRST ? {shift_q[PIX_BITS-2:0], 1'b0} : {1'b0, shift_q[PIX_BITS-1:1]};
    assign hi_end     = cur_bit ? TW'(T1_HI - 1) : TW'(T0_HI - 1);
    assign period_end = (clk_cnt_q == TW'(T_PERIOD - 1));
    assign last_bit   = (bit_idx_q == BW'(PIX_BITS - 1));
    assign last_pix   = ({1'b0, pix_idx_q} == (npix_q - (ADDR_W + 1)'(1)));
    assign gap_end    = (gap_q == RW'(T_RESET - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && (num_clamped != '0)) state_d = StLoad;
            StLoad: state_d = StSend;
            StSend: if (period_end && last_bit && last_pix) state_d = StGap;
            StGap:  if (gap_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        clk_cnt_d = clk_cnt_q;
        pix_idx_d = pix_idx_q;
        addr_d    = addr_q;
        npix_d    = npix_q;
        gap_d     = gap_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        addr_d = '0;
                        npix_d = num_clamped;
                    end
                end
            end
            StLoad: begin
                shift_d   = ram_rd_data;
                dout_d    = 1'b1;
                bit_idx_d = '0;
                clk_cnt_d = '0;
                pix_idx_d = '0;
            end
            StSend: begin
                clk_cnt_d = clk_cnt_q + TW'(1);
                if (clk_cnt_q == hi_end) dout_d = 1'b0;
                // Prefetch early in the last bit so the next word is stable at the pixel boundary.
                if (last_bit && (clk_cnt_q == '0) && !last_pix) addr_d = addr_q + ADDR_W'(1);
                if (period_end) begin
                    clk_cnt_d = '0;
                    if (!last_bit) begin
                        shift_d   = shifted;
                        bit_idx_d = bit_idx_q + BW'(1);
                        dout_d    = 1'b1;
                    end else if (!last_pix) begin
                        shift_d   = ram_rd_data;
                        pix_idx_d = pix_idx_q + ADDR_W'(1);
                        bit_idx_d = '0;
                        dout_d    = 1'b1;
                    end else begin
                        dout_d = 1'b0;
                        gap_d  = '0;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q + RW'(1);
                if (gap_end) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            clk_cnt_q <= '0;
            pix_idx_q <= '0;
            addr_q    <= '0;
            npix_q    <= '0;
            gap_q     <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            clk_cnt_q <= clk_cnt_d;
            pix_idx_q <= pix_idx_d;
            addr_q    <= addr_d;
            npix_q    <= npix_d;
            gap_q     <= gap_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ram_rd_addr = addr_q;
    assign dout        = dout_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_neopixel_chain_tx.sv
// Scoreboard bench for neopixel_chain_tx: three configurations, a dout pulse decoder that
// checks every bit and every done pulse against expectations queued by the stimulus.
module tb_neopixel_chain_tx;
    typedef struct { int dut; int hi; int addr; } bit_t;
    typedef struct { int dut; int cyc; } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  start_w;
    logic [2:0]  dout_w, busy_w, done_w;
    logic [8:0]  num_w  [3];
    logic [7:0]  addr_w [3];
    logic [23:0] rd_a, rd_c;
    logic [31:0] rd_b;
    logic [31:0] mem [3][256];

    int tper[3]   = '{15, 15, 3};
    int treset[3] = '{600, 961, 8};
    int pbits[3]  = '{24, 32, 24};
    int t1[3]     = '{10, 7, 2};
    int t0[3]     = '{5, 8, 1};
    bit msbf[3]   = '{1'b1, 1'b0, 1'b1};

    bit_t   bq[$];
    frame_t fq[$];
    frame_t fr;
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    int     hi[3] = '{0, 0, 0};
    int     lo[3] = '{0, 0, 0};
    logic   prev_dout[3];
    logic [7:0] prev_addr[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_a <= mem[0][addr_w[0]][23:0];
        rd_b <= mem[1][addr_w[1]];
        rd_c <= mem[2][addr_w[2]][23:0];
    end

    neopixel_chain_tx u_a (
        .clk(clk), .rst(rst), .start(start_w[0]), .num_pixels(num_w[0]),
        .ram_rd_addr(addr_w[0]), .ram_rd_data(rd_a), .dout(dout_w[0]), .busy(busy_w[0]),
        .done(done_w[0])
    );

    neopixel_chain_tx #(
        .PIX_BITS(32), .T_PERIOD(15), .T1_HI(7), .T0_HI(8), .T_RESET(961), .MSB_FIRST(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_w[1]), .num_pixels(num_w[1]),
        .ram_rd_addr(addr_w[1]), .ram_rd_data(rd_b), .dout(dout_w[1]), .busy(busy_w[1]),
        .done(done_w[1])
    );

    neopixel_chain_tx #(
        .T_PERIOD(3), .T1_HI(2), .T0_HI(1), .T_RESET(8)
    ) u_c (
        .clk(clk), .rst(rst), .start(start_w[2]), .num_pixels(num_w[2]),
        .ram_rd_addr(addr_w[2]), .ram_rd_data(rd_c), .dout(dout_w[2]), .busy(busy_w[2]),
        .done(done_w[2])
    );

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_bit(input int k, input int h, input int l, input int extra, input int a);
        bit_t e;
        if (bq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bit_unexpected dut=%0d got hi=%0d expected no bit", k, h);
            return;
        end
        e = bq.pop_front();
        check_eq("bit_dut", k, e.dut);
        check_eq("bit_hi", h, e.hi);
        check_eq("bit_lo", l, tper[k] - e.hi + extra);
        check_eq("bit_addr", a, e.addr);
    endtask

    // Decode dout per DUT: a bit ends at the next rising edge, the frame's last bit at done.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                hi[k] = 0;
                lo[k] = 0;
                prev_dout[k] = 1'b0;
            end else begin
                if (done_w[k]) begin
                    if (fq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_unexpected dut=%0d got done=1 expected 0", k);
                    end else begin
                        fr = fq.pop_front();
                        check_eq("done_dut", k, fr.dut);
                        check_eq("done_cycle", cyc, fr.cyc);
                    end
                    check_eq("busy_at_done", int'(busy_w[k]), 0);
                    if (hi[k] > 0) check_bit(k, hi[k], lo[k], treset[k], int'(prev_addr[k]));
                    hi[k] = 0;
                    lo[k] = 0;
                end else if (dout_w[k] && !prev_dout[k]) begin
                    if (hi[k] > 0) check_bit(k, hi[k], lo[k], 0, int'(prev_addr[k]));
                    hi[k] = 1;
                    lo[k] = 0;
                end else if (dout_w[k]) begin
                    hi[k]++;
                end else if (hi[k] > 0) begin
                    lo[k]++;
                end
                prev_dout[k] = dout_w[k];
                prev_addr[k] = addr_w[k];
            end
        end
    end

    task automatic push_bits(input int k, input int n);
        bit_t e;
        logic [31:0] w;
        for (int p = 0; p < n; p++) begin
            w = mem[k][p];
            for (int b = 0; b < pbits[k]; b++) begin
                e.dut  = k;
                e.hi   = (msbf[k] ? w[pbits[k] - 1 - b] : w[b]) ? t1[k] : t0[k];
                e.addr = (b == pbits[k] - 1 && p < n - 1) ? p + 1 : p;
                bq.push_back(e);
            end
        end
    endtask

    task automatic run_frame(input int k, input int n_req, input int n_exp);
        int c;
        frame_t f;
        @(negedge clk);
        push_bits(k, n_exp);
        num_w[k]   = 9'(n_req);
        start_w[k] = 1'b1;
        c = cyc;
        f.dut = k;
        f.cyc = (n_exp == 0) ? c + 1 : c + 2 + n_exp * pbits[k] * tper[k] + treset[k];
        fq.push_back(f);
        @(negedge clk);
        start_w[k] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (fq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_timeout", fq.size(), 0);
        check_eq("bits_left", bq.size(), 0);
        fq.delete();
        bq.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        start_w = '0;
        for (int k = 0; k < 3; k++) begin
            num_w[k] = '0;
            prev_dout[k] = 1'b0;
            prev_addr[k] = '0;
            for (int i = 0; i < 256; i++) mem[k][i] = '0;
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_dout", int'(dout_w[k]), 0);
            check_eq("rst_busy", int'(busy_w[k]), 0);
            check_eq("rst_done", int'(done_w[k]), 0);
            check_eq("rst_addr", int'(addr_w[k]), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // One pixel, default timing.
        mem[0][0] = 32'h00FE0000;
        run_frame(0, 1, 1);
        wait_idle(2000);

        // Three pixels back to back; a num_pixels change mid-frame must not matter.
        mem[0][0] = 32'h00FFFFFF;
        mem[0][1] = 32'h00000000;
        mem[0][2] = 32'h00A5A5A5;
        run_frame(0, 3, 3);
        repeat (20) @(negedge clk);
        num_w[0] = 9'd1;
        wait_idle(3000);

        // RGBW, LSB first, custom timing.
        mem[1][0] = 32'h00000001;
        run_frame(1, 1, 1);
        wait_idle(3000);

        // Empty frame: done on the next edge, nothing else moves.
        run_frame(0, 0, 0);
        wait_idle(20);
        check_eq("zero_busy", int'(busy_w[0]), 0);
        check_eq("zero_addr", int'(addr_w[0]), 0);

        // Clamped request: 300 -> 256 pixels, addresses 0..255.
        for (int i = 0; i < 256; i++) mem[2][i] = {8'h00, 8'(i), ~8'(i), 8'(i) ^ 8'h5A};
        run_frame(2, 300, 256);
        wait_idle(30000);

        // Ignored re-start mid-frame, then asynchronous reset at the start of pixel 1.
        mem[0][0] = 32'h0000FF00;
        mem[0][1] = 32'h000F0F0F;
        run_frame(0, 2, 2);
        repeat (50) @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (310) @(posedge clk);
        #2;
        check_eq("pre_rst_dout", int'(dout_w[0]), 1);
        check_eq("pre_rst_busy", int'(busy_w[0]), 1);
        check_eq("pre_rst_addr", int'(addr_w[0]), 1);
        #1 rst = 1'b1;
        bq.delete();
        fq.delete();
        #1;
        check_eq("async_rst_dout", int'(dout_w[0]), 0);
        check_eq("async_rst_busy", int'(busy_w[0]), 0);
        check_eq("async_rst_done", int'(done_w[0]), 0);
        check_eq("async_rst_addr", int'(addr_w[0]), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(0, 1, 1);
        wait_idle(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
